// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: state encoding shared by the skid register and its bench
package pipe_skid_reg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready/data handshake bundle
interface pipe_skid_reg_if #(parameter int WIDTH = 8);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg_flopenr_n.sv
// flopenr_n: enabled register with asynchronous active-low clear
module flopenr_n #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register, ready derived from state only
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_skid_reg_if.slave        s,
  pipe_skid_reg_if.master       m,
  output logic [1:0]            count
);
  state_t           state_q, state_d;
  logic             main_en, skid_en, sel_skid;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             s_fire, m_fire;
  assign s.ready = state_q != ST_FULL;
  assign m.valid = state_q != ST_EMPTY;
  assign m.data  = main_q;
  assign count   = state_q == ST_FULL ? 2'd2 : state_q == ST_ONE ? 2'd1 : 2'd0;
  assign s_fire  = s.valid & s.ready;
  assign m_fire  = m.valid & m.ready;
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    sel_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (s_fire) begin
        main_en = 1'b1;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        main_en = s_fire & m_fire;
        skid_en = s_fire & ~m_fire;
        state_d = s_fire & ~m_fire ? ST_FULL : ~s_fire & m_fire ? ST_EMPTY : ST_ONE;
      end
      ST_FULL: if (m_fire) begin
        main_en  = 1'b1;
        sel_skid = 1'b1;
        state_d  = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush drops any incoming word; stale payload is masked by m_valid=0
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= ST_EMPTY;
    else state_q <= state_d;
  flopenr_n #(.WIDTH(WIDTH)) u_main (
    .clk  (clk),
    .rst_n(reset),
    .en_i (main_en),
    .d_i  (sel_skid ? skid_q : s.data),
    .q_o  (main_q)
  );
  flopenr_n #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rst_n(reset),
    .en_i (skid_en),
    .d_i  (s.data),
    .q_o  (skid_q)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench with a bounded-FIFO reference model
module tb_pipe_skid_reg;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] count;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  pipe_skid_reg_if #(.WIDTH(8)) s_if ();
  pipe_skid_reg_if #(.WIDTH(8)) m_if ();
  pipe_skid_reg #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .s    (s_if),
    .m    (m_if),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    s_if.valid = v;
    s_if.data  = d;
    m_if.ready = r;
    flush      = f;
  endtask
  // Model: the block is a FIFO of depth 2 whose ready depends only on occupancy
  always @(negedge clk) begin
    int n;
    if (!reset) begin
      check("rst_m_valid", m_if.valid, 0);
      check("rst_m_data", m_if.data, 0);
      check("rst_count", count, 0);
      check("rst_s_ready", s_if.ready, 1);
      sb.delete();
    end else begin
      n = sb.size();
      check("count", count, n);
      check("s_ready", s_if.ready, n < 2);
      check("m_valid", m_if.valid, n != 0);
      if (n != 0) check("m_data", m_if.data, sb[0]);
      if (n != 0 && m_if.ready) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (s_if.valid && n < 2) sb.push_back(s_if.data);
    end
  end
  initial begin
    s_if.valid = 1'b1;
    s_if.data  = 8'hAA;
    m_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    s_if.valid = 1'b0;
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    repeat (3) step(1, 8'hA3, 0, 0);
    repeat (2) step(1, 8'hA3, 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    step(1, 8'h55, 0, 1);
    step(0, 8'h00, 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'hC1, 0, 0);
    step(1, 8'hC2, 0, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_m_valid", m_if.valid, 0);
    check("async_count", count, 0);
    check("async_m_data", m_if.data, 0);
    check("async_s_ready", s_if.ready, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'h77;
    m_if.ready = 1'b1;
    repeat (3) step(0, 8'h00, 1, 0);
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0);
    repeat (4) step(0, 8'h00, 1, 0);
    @(posedge clk);
    #1 check("drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
